// File: rtl/acc_pkg.sv
// acc_pkg: shared op-code and FSM state types for the accumulator bank
package acc_pkg;
  typedef enum logic [2:0] {NOP, LOAD, LOAD_ALU, INC, STEP, ADD, CLEAR, CLEAR_ALL} acc_op_t;
  typedef enum logic {IDLE, SWEEP} acc_state_t;
endpackage

// File: rtl/acc_update.sv
// acc_update: next-value and overflow for one accumulator under one op.
//   op       in   operation applied to the selected channel
//   acc      in   current channel value
//   data_in  in   operand for LOAD / ADD
//   alu_out  in   operand for LOAD_ALU
//   acc_d    out  next channel value
//   ovf_d    out  carry out of INC / STEP / ADD
// ACC_SATURATE_EN: clamp to all-ones on overflow instead of wrapping.
module acc_update import acc_pkg::*; #(
  parameter int WORD_SIZE = 16,
  parameter int STRIDE    = 8
) (
  input  acc_op_t              op,
  input  logic [WORD_SIZE-1:0] acc,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic [WORD_SIZE-1:0] alu_out,
  output logic [WORD_SIZE-1:0] acc_d,
  output logic                 ovf_d
);
  logic                 arith;
  logic [WORD_SIZE-1:0] addend, res;
  logic [WORD_SIZE:0]   sum;
  always_comb begin
    arith  = op inside {INC, STEP, ADD};
    addend = op == INC ? WORD_SIZE'(1) : op == STEP ? WORD_SIZE'(STRIDE) : data_in;
    sum    = {1'b0, acc} + {1'b0, addend};
    ovf_d  = arith & sum[WORD_SIZE];
`ifdef ACC_SATURATE_EN
    res    = sum[WORD_SIZE] ? '1 : sum[WORD_SIZE-1:0];
`else
    res    = sum[WORD_SIZE-1:0];
`endif
    acc_d  = op == LOAD ? data_in : op == LOAD_ALU ? alu_out : op == CLEAR ? '0 : arith ? res : acc;
  end
endmodule

// File: rtl/acc_bank.sv
// acc_bank: NUM_ACC unsigned accumulators with sticky overflow and clear-all sweep.
//   clk, rst             clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake
//   cmd_op, cmd_sel      operation and target channel
//   data_in, alu_out     operands
//   rd_sel, data_out     combinational read port
//   ovf                  sticky overflow per channel
//   busy                 clear-all sweep in progress
// ACC_SATURATE_EN (in acc_update): saturating instead of wrapping arithmetic.
module acc_bank import acc_pkg::*; #(
  parameter  int WORD_SIZE = 16,
  parameter  int NUM_ACC   = 4,
  parameter  int STRIDE    = 8,
  localparam int SEL_W     = $clog2(NUM_ACC)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [SEL_W-1:0]     cmd_sel,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic [WORD_SIZE-1:0] alu_out,
  input  logic [SEL_W-1:0]     rd_sel,
  output logic [WORD_SIZE-1:0] data_out,
  output logic [NUM_ACC-1:0]   ovf,
  output logic                 busy
);
  logic [WORD_SIZE-1:0] acc_q [NUM_ACC];
  logic [NUM_ACC-1:0]   ovf_q;
  acc_state_t           state_q;
  logic [SEL_W-1:0]     idx_q;
  logic                 ready_q, busy_q;
  acc_op_t              op;
  logic                 accept, sel_ok, start, last, ovf_d;
  logic [WORD_SIZE-1:0] cur, acc_d;
  assign op        = acc_op_t'(cmd_op);
  assign accept    = cmd_valid & ready_q;
  assign start     = accept && op == CLEAR_ALL;
  assign sel_ok    = 32'(cmd_sel) < NUM_ACC;
  assign last      = 32'(idx_q) == NUM_ACC - 1;
  assign cur       = sel_ok ? acc_q[cmd_sel] : '0;
  assign data_out  = 32'(rd_sel) < NUM_ACC ? acc_q[rd_sel] : '0;
  assign ovf       = ovf_q;
  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  acc_update #(.WORD_SIZE(WORD_SIZE), .STRIDE(STRIDE)) u_update (
    .op(op), .acc(cur), .data_in(data_in), .alu_out(alu_out), .acc_d(acc_d), .ovf_d(ovf_d)
  );
  // ready_q resets low so cmd_ready only rises on the first edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
      ovf_q   <= '0;
      state_q <= IDLE;
      idx_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      ready_q <= !start;
      busy_q  <= start;
      idx_q   <= '0;
      if (start) state_q <= SWEEP;
      else if (accept && sel_ok) begin
        acc_q[cmd_sel] <= acc_d;
        ovf_q[cmd_sel] <= ovf_d | (ovf_q[cmd_sel] & !(op inside {LOAD, LOAD_ALU, CLEAR}));
      end
    end else begin
      acc_q[idx_q] <= '0;
      ovf_q[idx_q] <= 1'b0;
      idx_q        <= last ? '0 : idx_q + SEL_W'(1);
      state_q      <= last ? IDLE : SWEEP;
      ready_q      <= last;
      busy_q       <= !last;
    end
  end
endmodule

// File: tb/tb_acc_bank.sv
// tb_acc_bank: scoreboard bench for acc_bank driven by directed steps.
module tb_acc_bank;
  import acc_pkg::*;
  logic        clk = 0, rst = 0, cmd_valid = 0;
  logic [2:0]  cmd_op = 0;
  logic [1:0]  cmd_sel = 0, rd_sel = 0;
  logic [15:0] data_in = 0, alu_out = 0, data_out;
  logic        cmd_ready, busy;
  logic [3:0]  ovf;
  int          compared = 0, mismatched = 0, step = 0;
  logic [15:0] m [4];
  logic [3:0]  mo;
  typedef struct {int step; logic [1:0] sel; logic [15:0] val;} exp_t;
  exp_t sb [$];

  acc_bank dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_sel(cmd_sel), .data_in(data_in), .alu_out(alu_out), .rd_sel(rd_sel),
    .data_out(data_out), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] sel);
    sb.push_back('{step, sel, m[sel]});
  endtask

  task automatic push_all();
    for (int i = 0; i < 4; i++) push(2'(i));
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_sel = e.sel;
      #1;
      compared++;
      assert (data_out === e.val) else begin
        mismatched++;
        $error("FAIL acc step%0d ch%0d: observed %h expected %h", e.step, e.sel, data_out, e.val);
      end
    end
  endtask

  task automatic apply(input logic [2:0] op, input logic [1:0] sel, input logic [15:0] d);
    logic [16:0] s;
    case (op)
      3'd1: begin m[sel] = d; mo[sel] = 1'b0; end
      3'd2: begin m[sel] = alu_out; mo[sel] = 1'b0; end
      3'd3, 3'd4, 3'd5: begin
        s = {1'b0, m[sel]} + (op == 3'd3 ? 17'd1 : op == 3'd4 ? 17'd8 : {1'b0, d});
        if (s[16]) begin
          mo[sel] = 1'b1;
`ifdef ACC_SATURATE_EN
          m[sel] = 16'hFFFF;
`else
          m[sel] = s[15:0];
`endif
        end else m[sel] = s[15:0];
      end
      3'd6: begin m[sel] = 16'h0; mo[sel] = 1'b0; end
      default: ;
    endcase
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [1:0] sel, input logic [15:0] d);
    cmd_valid = 1; cmd_op = op; cmd_sel = sel; data_in = d;
    @(negedge clk);
    cmd_valid = 0;
    apply(op, sel, d);
    step++;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m[i] = 16'h0;
    mo = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    push_all(); drain();
    @(negedge clk);
    rst = 1;
    #1 chk("ready_after_release", cmd_ready, 0);
    @(negedge clk);
    chk("ready_first_edge", cmd_ready, 1);
    // load and read-back
    do_cmd(LOAD, 1, 16'h1234); push_all(); drain();
    chk("ovf_after_load", ovf, mo);
    // step and increment
    do_cmd(LOAD, 0, 16'h0010);
    do_cmd(STEP, 0, 0); push(0); drain();
    chk("step_val", data_out, 16'h0018);
    do_cmd(INC, 0, 0); push(0); drain();
    // add overflow, then clear flag with LOAD
    do_cmd(LOAD, 2, 16'hFFF0);
    do_cmd(ADD, 2, 16'h0020); push(2); drain();
`ifdef ACC_SATURATE_EN
    chk("add_ovf_val", data_out, 16'hFFFF);
`else
    chk("add_ovf_val", data_out, 16'h0010);
`endif
    chk("ovf_add", ovf, mo);
    do_cmd(LOAD, 2, 16'h0005); push(2); drain();
    chk("ovf_cleared", ovf, mo);
    // increment overflow, flag sticky across a non-overflowing add
    do_cmd(LOAD, 3, 16'hFFFF);
    do_cmd(INC, 3, 0); push(3); drain();
    chk("ovf_inc", ovf, mo);
    do_cmd(ADD, 3, 16'h0000); push(3); drain();
    chk("ovf_sticky", ovf, mo);
    // clear-all sweep with a held INC behind it
    for (int i = 0; i < 4; i++) do_cmd(LOAD, 2'(i), 16'h1111 * 16'(i + 1));
    cmd_valid = 1; cmd_op = CLEAR_ALL; cmd_sel = 0;
    @(negedge clk);
    cmd_op = INC; cmd_sel = 3;
    step++;
    chk("sweep_ready", cmd_ready, 0);
    chk("sweep_busy", busy, 1);
    push_all(); drain();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      m[k] = 16'h0; mo[k] = 1'b0; step++;
      chk("sweep_ready_k", cmd_ready, 32'(k == 3));
      chk("sweep_busy_k", busy, 32'(k != 3));
      push_all(); drain();
    end
    @(negedge clk);
    cmd_valid = 0;
    apply(INC, 3, 0); step++;
    push_all(); drain();
    chk("ovf_after_sweep", ovf, mo);
    // reset during the second sweep cycle
    do_cmd(LOAD, 1, 16'h0077);
    do_cmd(LOAD, 2, 16'h0088);
    cmd_valid = 1; cmd_op = CLEAR_ALL;
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 4; i++) m[i] = 16'h0;
    mo = 4'h0; step++;
    #1 chk("midrst_busy", busy, 0);
    chk("midrst_ready", cmd_ready, 0);
    push_all(); drain();
    chk("midrst_ovf", ovf, mo);
    @(negedge clk);
    rst = 1;
    #1 chk("midrst_release_ready", cmd_ready, 0);
    @(negedge clk);
    chk("midrst_ready_edge", cmd_ready, 1);
    chk("midrst_busy_edge", busy, 0);
    // ALU load, NOP, clear
    alu_out = 16'hBEEF;
    do_cmd(LOAD_ALU, 0, 0); push(0); drain();
    chk("alu_val", data_out, 16'hBEEF);
    do_cmd(NOP, 0, 16'h1234); push_all(); drain();
    do_cmd(CLEAR, 0, 0); push_all(); drain();
    chk("ovf_final", ovf, mo);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/acc_bank.md
# acc_bank

Parametrised multi-channel accumulator bank for the matrix-multiplication datapath. It holds NUM_ACC independent unsigned accumulators, each WORD_SIZE bits wide. One command is applied per cycle over a valid/ready handshake: load, load-from-ALU, increment, stride step, add, clear, or a multi-cycle clear-all sweep. Each channel carries a sticky overflow flag, and any channel can be read at any time through a read-select port.

## Interface
- WORD_SIZE, 16: accumulator width in bits.
- NUM_ACC, 4: number of accumulator channels, at least 2.
- STRIDE, 8: increment applied by the STEP op, unsigned, below 2^WORD_SIZE.
- SEL_W, $clog2(NUM_ACC): select width (derived, not overridden).
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  bank can accept a command.
- cmd_op  in  3  operation code, encoding in Operation.
- cmd_sel  in  SEL_W  target channel.
- data_in  in  WORD_SIZE  operand for LOAD and ADD.
- alu_out  in  WORD_SIZE  operand for LOAD_ALU.
- rd_sel  in  SEL_W  read channel.
- data_out  out  WORD_SIZE  acc[rd_sel], combinational read of the registered state.
- ovf  out  NUM_ACC  sticky overflow flag per channel.
- busy  out  1  clear-all sweep in progress.

## Operation
- A command is accepted when cmd_valid and cmd_ready are both 1 on a rising edge. Only accepted commands change state.
- Op codes:
  - 0 NOP: no change.
  - 1 LOAD: acc = data_in.
  - 2 LOAD_ALU: acc = alu_out.
  - 3 INC: acc + 1.
  - 4 STEP: acc + STRIDE.
  - 5 ADD: acc + data_in.
  - 6 CLEAR: acc = 0.
  - 7 CLEAR_ALL: starts the sweep.
- Arithmetic is unsigned. Addition is computed WORD_SIZE+1 bits wide; overflow is the carry out.
- Overflow on INC, STEP or ADD sets ovf[sel]. The flag stays set until LOAD, LOAD_ALU, CLEAR or a sweep clears that channel.
- The result on overflow depends on ACC_SATURATE_EN (see Configuration).
- A cmd_sel of NUM_ACC or above (non-power-of-2 NUM_ACC) is accepted and ignored. An out-of-range rd_sel reads 0.
- FSM states:
  - IDLE: cmd_ready=1, busy=0. An accepted CLEAR_ALL moves to SWEEP with idx=0.
  - SWEEP: cmd_ready=0, busy=1. Each cycle clears acc[idx] and ovf[idx], then increments idx. The cycle that clears idx=NUM_ACC-1 returns to IDLE.
- Only one command is in flight, so simultaneous ops on one channel cannot occur.
- data_out tracks rd_sel combinationally. It shows the post-edge value in the cycle after a command.

## Timing
- Reset (rst=0, asynchronous): all accumulators 0, ovf=0, state IDLE, idx=0.
  - Outputs during reset: cmd_ready=0, busy=0, data_out=0.
  - cmd_ready rises on the first clock edge after rst deasserts.
- Single-cycle ops: result is registered on the accepting edge, giving 1-cycle latency to data_out.
- CLEAR_ALL: the accepting edge enters SWEEP. The next NUM_ACC edges each clear one channel.
  - cmd_ready is 0 for exactly NUM_ACC cycles, then 1.
  - A channel not yet swept keeps its value and stays readable.
- Reset mid-sweep aborts immediately: all state returns to reset values.
- cmd_valid may stay high while cmd_ready=0. The command is held by the source and accepted once cmd_ready returns.

## Configuration
- ACC_SATURATE_EN defined: on overflow the accumulator clamps to 2^WORD_SIZE-1 and ovf[sel] is set.
- ACC_SATURATE_EN undefined: on overflow the accumulator wraps modulo 2^WORD_SIZE and ovf[sel] is set.
- No other behaviour differs between the two builds.

## Structure
- Shared package acc_pkg holds:
  - the op-code enum typedef (acc_op_t: NOP, LOAD, LOAD_ALU, INC, STEP, ADD, CLEAR, CLEAR_ALL);
  - the FSM state typedef (IDLE, SWEEP).
- Sub-module acc_update: combinational, with inputs op, current acc, data_in, alu_out and STRIDE, and outputs next acc and overflow bit. Saturation is applied here under ACC_SATURATE_EN.
- acc_bank instantiates one acc_update and muxes the selected channel into it. It holds the register array, flags, FSM and sweep index.

## Test plan
- Reset and load: rst low for 3 cycles, then LOAD ch1 with 0x1234 → data_out(rd_sel=1)=0x1234 next cycle; other channels read 0; ovf=0.
- Step and increment: LOAD ch0 0x0010, then STEP, then INC → ch0 reads 0x0018, then 0x0019.
- Overflow: LOAD ch2 0xFFF0, then ADD 0x0020 → with ACC_SATURATE_EN ch2=0xFFFF and ovf[2]=1; without it ch2=0x0010 and ovf[2]=1. A following LOAD 5 → ovf[2]=0.
- Sweep: all channels loaded nonzero, then CLEAR_ALL with cmd_valid held high carrying INC ch3 → cmd_ready=0 and busy=1 for 4 cycles, channels zero in order 0..3, then INC accepted and ch3=1.
- Reset mid-sweep: assert rst on the 2nd sweep cycle → all accumulators 0, busy=0 immediately; cmd_ready=1 on the first edge after release.
- ALU path and ignore: LOAD_ALU ch0 with alu_out=0xBEEF → 0xBEEF. NOP with cmd_valid=1 → no channel changes.
